axis_pps_trigger_sched: RTL and testbench
=========================================

Name: axis_pps_trigger_sched

Overview:
- Schedules one-shot trigger pulses aligned to the PPS time base.
- Commands arrive on an AXI-Stream slave. Each command gives a delay in whole seconds plus a cycle offset within the target second.
- The block tracks PPS lock and loss, fires a single-cycle trig pulse, and returns one status word per command on an AXI-Stream master.
- It sits beside the PPS counter and drives ADC/DAC gating logic and DMA start logic.

Parameters:
- CNTR_WIDTH, 32: width of the intra-second cycle counter and of the offset field.
- SEC_WIDTH, 16: width of the seconds-delay field.
- S_AXIS_TDATA_WIDTH, 64: command width. Must be >= CNTR_WIDTH+SEC_WIDTH. Upper unused bits are ignored.
- TIMEOUT, 130000000: cycles without a PPS edge before loss is declared.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- pps_data  in  1  asynchronous PPS input
- abort  in  1  level; cancels a pending command
- s_axis_tdata  in  S_AXIS_TDATA_WIDTH  command: [CNTR_WIDTH-1:0] = offset, [CNTR_WIDTH+SEC_WIDTH-1:CNTR_WIDTH] = delay
- s_axis_tvalid  in  1  command valid
- s_axis_tready  out  1  command accept
- m_axis_tdata  out  32  status word
- m_axis_tvalid  out  1  status valid
- m_axis_tready  in  1  status accept
- trig  out  1  one-cycle trigger pulse
- pps_lock  out  1  PPS present
- pps_lost  out  1  PPS timeout occurred

Behaviour:
- Reset: aresetn is synchronous, active-low; the clock is aclk. On reset all registers clear; state=IDLE, trig=0, m_axis_tvalid=0, s_axis_tready=0, pps_lock=0, pps_lost=0, seq=0.
- PPS sync and edge detect:
  - 3-bit shift register on pps_data; edge = ~d[2] & d[1].
  - The edge is seen 2 cycles after the input rises.
- Cycle counter cntr:
  - Cleared to 0 in the cycle after an edge; otherwise increments by 1.
  - Saturates at TIMEOUT (no wrap).
- Lock and loss flags:
  - pps_lock sets on any edge. It clears in the cycle cntr reaches TIMEOUT.
  - pps_lost sets in that same cycle and clears on the next edge.
  - If an edge and cntr==TIMEOUT occur in the same cycle, the edge wins.
- s_axis_tready = (state==IDLE) & pps_lock. On handshake, latch sec_reg=delay and off_reg=offset, then go to ARM.
- ARM state: on each edge, if sec_reg==0 go to WAIT_CYC, else decrement sec_reg. Delay 0 therefore targets the second that starts at the next edge.
- WAIT_CYC state:
  - If cntr==off_reg, fire: trig=1 in the following cycle (registered), status ok, go to REPORT.
  - Offset 0 fires 2 cycles after the edge cycle.
  - Edge in the same cycle as the match: the match wins.
  - Edge without a match means the offset exceeded the second: status MISS, go to REPORT, no trig.
- Abort conditions, checked in ARM and WAIT_CYC:
  - pps_lost rising: status LOST, no trig.
  - abort=1: status ABORT, no trig.
  - Priority: fire > LOST > ABORT > MISS.
- REPORT state:
  - m_axis_tvalid=1; m_axis_tdata is held stable until m_axis_tready.
  - On handshake: seq increments (wraps at 16 bits), go to IDLE.
- Status word: [31]=ok, [30]=MISS, [29]=LOST, [28]=ABORT, [27:16]=0, [15:0]=seq.
- abort in IDLE or REPORT has no effect.
- Reset mid-operation discards the pending command with no status emitted and no trig.

Decomposition:
- Shared package holds:
  - state enum {IDLE, ARM, WAIT_CYC, REPORT};
  - status bit index constants;
  - the command field offset/width localparams.
- One natural sub-module: axis_pps_sync. It contains the synchronizer, edge detect, cycle counter and lock/lost flags, and outputs edge, cntr, pps_lock and pps_lost. The FSM lives in the top.

Test Plan:
- 1 Hz PPS (1000-cycle period, TIMEOUT=1500); command delay=0, offset=100 after lock -> trig exactly once, 102 cycles after the edge cycle; status 0x80000000; next status seq=1.
- delay=2, offset=0 -> trig in the second after the third edge following acceptance, 2 cycles after that edge; exactly one pulse.
- offset=1200 (beyond the 1000-cycle period) -> no trig; status 0x40000000 at the next edge.
- Stop PPS while in ARM -> pps_lost and pps_lock=0 at cntr=1500; status 0x20000000; s_axis_tready stays 0 until the next edge.
- abort pulse in WAIT_CYC -> status 0x10000000, no trig. Hold m_axis_tready=0 for 10 cycles -> tvalid and tdata stable throughout; no new command accepted.
- Reset asserted in WAIT_CYC -> all outputs 0 next cycle; no status emitted; after reset, s_axis_tready stays 0 until the first edge.

Source files
------------

// File: rtl/axis_pps_trigger_sched_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | axis_pps_trigger_sched_pkg                                             |
// | Shared FSM states, status-word layout and command-field helpers.       |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package axis_pps_trigger_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARM      = 2'd1,
    ST_WAIT_CYC = 2'd2,
    ST_REPORT   = 2'd3
  } state_t;

  localparam int c_stat_ok_bit    = 31;
  localparam int c_stat_miss_bit  = 30;
  localparam int c_stat_lost_bit  = 29;
  localparam int c_stat_abort_bit = 28;
  localparam int c_seq_width      = 16;

  // Command layout: offset in the low bits, delay directly above it.
  localparam int c_offset_lsb = 0;

  function automatic int cmd_delay_lsb(input int cntr_width);
    return c_offset_lsb + cntr_width;
  endfunction

  function automatic logic [31:0] make_status(
    input logic                   ok,
    input logic                   miss,
    input logic                   lost,
    input logic                   abrt,
    input logic [c_seq_width-1:0] seq
  );
    logic [31:0] w;
    w                   = '0;
    w[c_stat_ok_bit]    = ok;
    w[c_stat_miss_bit]  = miss;
    w[c_stat_lost_bit]  = lost;
    w[c_stat_abort_bit] = abrt;
    w[c_seq_width-1:0]  = seq;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_pps_sync.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | axis_pps_sync                                                          |
// | PPS synchronizer, rising-edge detect, intra-second counter, lock/loss. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module axis_pps_sync
  import axis_pps_trigger_sched_pkg::*;
#(
  parameter int CNTR_WIDTH = 32,
  parameter int TIMEOUT    = 130000000
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  pps_data,
  output logic                  pps_edge,
  output logic [CNTR_WIDTH-1:0] cntr,
  output logic                  pps_lock,
  output logic                  pps_lost
);

  localparam logic [CNTR_WIDTH-1:0] c_timeout = CNTR_WIDTH'(TIMEOUT);

  logic [2:0]            r_sync;
  logic [CNTR_WIDTH-1:0] r_cntr;
  logic                  r_lock;
  logic                  r_lost;
  logic                  w_edge;
  logic                  w_timeout;

  assign w_edge    = ~r_sync[2] & r_sync[1];
  assign w_timeout = (r_cntr == c_timeout);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_sync <= '0;
      r_cntr <= '0;
      r_lock <= 1'b0;
      r_lost <= 1'b0;
    end else begin
      r_sync <= {r_sync[1:0], pps_data};
      // Counter saturates so a missing PPS cannot wrap into a false match.
      if (w_edge)
        r_cntr <= '0;
      else if (!w_timeout)
        r_cntr <= r_cntr + CNTR_WIDTH'(1);
      // An edge arriving on the timeout cycle keeps the lock.
      if (w_edge) begin
        r_lock <= 1'b1;
        r_lost <= 1'b0;
      end else if (w_timeout) begin
        r_lock <= 1'b0;
        r_lost <= 1'b1;
      end
    end
  end

  assign pps_edge = w_edge;
  assign cntr     = r_cntr;
  assign pps_lock = r_lock;
  assign pps_lost = r_lost;

endmodule
`default_nettype wire

// File: rtl/axis_pps_trigger_sched.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | axis_pps_trigger_sched                                                 |
// | PPS-aligned one-shot trigger scheduler with AXI-Stream cmd/status.     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module axis_pps_trigger_sched
  import axis_pps_trigger_sched_pkg::*;
#(
  parameter int CNTR_WIDTH         = 32,
  parameter int SEC_WIDTH          = 16,
  parameter int S_AXIS_TDATA_WIDTH = 64,
  parameter int TIMEOUT            = 130000000
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          pps_data,
  input  logic                          abort,
  input  logic [S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [31:0]                   m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          trig,
  output logic                          pps_lock,
  output logic                          pps_lost
);

  localparam int c_delay_lsb = cmd_delay_lsb(CNTR_WIDTH);

  logic                   w_edge;
  logic [CNTR_WIDTH-1:0]  w_cntr;
  logic                   w_pps_lock;
  logic                   w_pps_lost;
  logic [CNTR_WIDTH-1:0]  w_offset;
  logic [SEC_WIDTH-1:0]   w_delay;

  state_t                 r_state;
  logic [SEC_WIDTH-1:0]   r_sec;
  logic [CNTR_WIDTH-1:0]  r_off;
  logic                   r_lost_d;
  logic                   r_trig;
  logic                   r_tvalid;
  logic [31:0]            r_tdata;
  logic [c_seq_width-1:0] r_seq;

  logic w_active;
  logic w_waiting;
  logic w_lost_rise;
  logic w_fire;
  logic w_lost_end;
  logic w_abort_end;
  logic w_miss_end;
  logic w_done;

  axis_pps_sync #(
    .CNTR_WIDTH (CNTR_WIDTH),
    .TIMEOUT    (TIMEOUT)
  ) u_sync (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .pps_data (pps_data),
    .pps_edge (w_edge),
    .cntr     (w_cntr),
    .pps_lock (w_pps_lock),
    .pps_lost (w_pps_lost)
  );

  assign w_offset = s_axis_tdata[c_offset_lsb +: CNTR_WIDTH];
  assign w_delay  = s_axis_tdata[c_delay_lsb +: SEC_WIDTH];

  generate
    if (S_AXIS_TDATA_WIDTH > CNTR_WIDTH + SEC_WIDTH) begin : g_unused_cmd_bits
      logic w_unused_tdata;
      assign w_unused_tdata = ^s_axis_tdata[S_AXIS_TDATA_WIDTH-1:CNTR_WIDTH+SEC_WIDTH];
    end
  endgenerate

  // Outcome priority: fire > LOST > ABORT > MISS.
  assign w_active    = (r_state == ST_ARM) || (r_state == ST_WAIT_CYC);
  assign w_waiting   = (r_state == ST_WAIT_CYC);
  assign w_lost_rise = w_pps_lost & ~r_lost_d;
  assign w_fire      = w_waiting && (w_cntr == r_off);
  assign w_lost_end  = w_active && !w_fire && w_lost_rise;
  assign w_abort_end = w_active && !w_fire && !w_lost_rise && abort;
  assign w_miss_end  = w_waiting && !w_fire && !w_lost_rise && !abort && w_edge;
  assign w_done      = w_fire | w_lost_end | w_abort_end | w_miss_end;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state  <= ST_IDLE;
      r_sec    <= '0;
      r_off    <= '0;
      r_lost_d <= 1'b0;
      r_trig   <= 1'b0;
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_seq    <= '0;
    end else begin
      r_trig   <= 1'b0;
      r_lost_d <= w_pps_lost;
      if (w_done) begin
        r_trig   <= w_fire;
        r_tvalid <= 1'b1;
        r_tdata  <= make_status(w_fire, w_miss_end, w_lost_end, w_abort_end, r_seq);
        r_state  <= ST_REPORT;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (s_axis_tvalid && w_pps_lock) begin
              r_sec   <= w_delay;
              r_off   <= w_offset;
              r_state <= ST_ARM;
            end
          end
          ST_ARM: begin
            if (w_edge) begin
              if (r_sec == '0)
                r_state <= ST_WAIT_CYC;
              else
                r_sec <= r_sec - SEC_WIDTH'(1);
            end
          end
          ST_WAIT_CYC: begin
          end
          ST_REPORT: begin
            if (m_axis_tready) begin
              r_tvalid <= 1'b0;
              r_seq    <= r_seq + c_seq_width'(1);
              r_state  <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign s_axis_tready = (r_state == ST_IDLE) && w_pps_lock;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tdata;
  assign trig          = r_trig;
  assign pps_lock      = w_pps_lock;
  assign pps_lost      = w_pps_lost;

endmodule
`default_nettype wire

// File: tb/tb_axis_pps_trigger_sched.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_axis_pps_trigger_sched                                              |
// | Directed bench with a cycle-timed reference model of the scheduler.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_axis_pps_trigger_sched;

  localparam int TO     = 1500;
  localparam int PERIOD = 1000;
  localparam int HIGH   = 50;

  logic        aclk          = 1'b0;
  logic        aresetn       = 1'b0;
  logic        pps_data      = 1'b0;
  logic        abort         = 1'b0;
  logic [63:0] s_axis_tdata  = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        m_axis_tready = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        trig;
  logic        pps_lock;
  logic        pps_lost;

  int total = 0;
  int bad   = 0;
  int cyc   = 1;

  axis_pps_trigger_sched #(
    .CNTR_WIDTH         (32),
    .SEC_WIDTH          (16),
    .S_AXIS_TDATA_WIDTH (64),
    .TIMEOUT            (TO)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .pps_data      (pps_data),
    .abort         (abort),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .trig          (trig),
    .pps_lock      (pps_lock),
    .pps_lost      (pps_lost)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // PPS source: one rising edge per PERIOD cycles while enabled.
  bit pps_en = 1'b0;
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge aclk);
      #1;
      if (pps_en) begin
        pps_data = (ph < HIGH);
        ph       = (ph + 1) % PERIOD;
      end else begin
        pps_data = 1'b0;
        ph       = 0;
      end
    end
  end

  // Reference model, evaluated at each negedge for the cycle just begun.
  // Cycle k spans posedge k .. posedge k+1; inputs for k are set at posedge k + #1.
  int      last_e     = -100000;
  int      base       = 0;
  bit      seen       = 1'b0;
  int      edge_cnt   = 0;
  int      trig_count = 0;

  initial begin
    bit          p1, p2, p3, e_k, lock_k, lost_k, lost_prev, lrise;
    bit          pend, rep;
    int          need, target, trig_at, k;
    longint      off_m;
    logic [15:0] seq_m;
    logic [31:0] exp_tdata;
    logic [3:0]  st;
    p1 = 0; p2 = 0; p3 = 0; lost_prev = 0;
    pend = 0; rep = 0; need = 0; target = -1; trig_at = -1; off_m = 0;
    seq_m = '0; exp_tdata = '0;
    forever begin
      @(negedge aclk);
      k      = cyc;
      e_k    = p2 & ~p3;
      lock_k = seen && (k - last_e <= TO + 1);
      lost_k = (k - base >= TO + 2);
      lrise  = lost_k & ~lost_prev;

      check("pps_lock", pps_lock, lock_k);
      check("pps_lost", pps_lost, lost_k);
      check("s_tready", s_axis_tready, !pend && !rep && lock_k);
      check("m_tvalid", m_axis_tvalid, rep);
      if (rep) check("m_tdata", m_axis_tdata, exp_tdata);
      check("trig", trig, trig_at == k);
      if (trig === 1'b1) trig_count++;

      if (!aresetn) begin
        pend = 0; rep = 0; seq_m = '0; trig_at = -1; target = -1;
        base = k; seen = 0; lost_prev = 0;
        p1 = 0; p2 = 0; p3 = 0;
      end else begin
        st = 4'b0000;
        if (rep) begin
          if (m_axis_tready) begin
            rep   = 0;
            seq_m = seq_m + 16'd1;
          end
        end else if (pend) begin
          if (target >= 0 && off_m <= TO && longint'(k) == longint'(target) + 1 + off_m) begin
            st = 4'b1000; trig_at = k + 1;
          end else if (lrise) st = 4'b0010;
          else if (abort) st = 4'b0001;
          else if (target >= 0 && e_k) st = 4'b0100;
          else if (target < 0 && e_k) begin
            need--;
            if (need == 0) target = k;
          end
          if (st != 4'b0000) begin
            pend      = 0;
            rep       = 1;
            exp_tdata = {st, 12'h000, seq_m};
          end
        end else if (lock_k && s_axis_tvalid) begin
          pend   = 1;
          need   = int'(s_axis_tdata[47:32]) + 1;
          off_m  = longint'(s_axis_tdata[31:0]);
          target = -1;
        end
        if (e_k) begin
          last_e = k; base = k; seen = 1; edge_cnt++;
        end
        lost_prev = lost_k;
        p3 = p2; p2 = p1; p1 = pps_data;
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_lock(input int budget);
    int n;
    n = 0;
    while (!pps_lock && n < budget) begin tick(); n++; end
    check("wait_lock", pps_lock, 1'b1);
  endtask

  task automatic send_cmd(input int delay, input int off, output int ec0);
    int n;
    s_axis_tdata  = {16'hA5A5, 16'(delay), 32'(off)};
    s_axis_tvalid = 1'b1;
    n = 0;
    while (!s_axis_tready && n < 3000) begin tick(); n++; end
    check("cmd_accept", s_axis_tready, 1'b1);
    tick();
    s_axis_tvalid = 1'b0;
    ec0 = edge_cnt;
  endtask

  task automatic wait_trig(input int budget, output int tcyc);
    int n;
    n = 0;
    while (!trig && n < budget) begin tick(); n++; end
    check("trig_seen", trig, 1'b1);
    tcyc = cyc;
  endtask

  task automatic wait_status(input string name, input logic [31:0] exp, input int hold);
    int n;
    n = 0;
    while (!m_axis_tvalid && n < 4000) begin tick(); n++; end
    check({name, "_valid"}, m_axis_tvalid, 1'b1);
    check(name, m_axis_tdata, exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", m_axis_tvalid, 1'b1);
      check("hold_data", m_axis_tdata, exp);
      check("hold_tready", s_axis_tready, 1'b0);
    end
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b0;
    tick();
    m_axis_tready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ec0, tc, tcnt0, n;
    repeat (5) tick();
    check("rst_outputs", {trig, m_axis_tvalid, s_axis_tready, pps_lock, pps_lost}, 5'b0);
    aresetn = 1'b1;
    pps_en  = 1'b1;
    wait_lock(2500);

    // delay 0, offset 100: trig 102 cycles after the target edge
    send_cmd(0, 100, ec0);
    wait_trig(2500, tc);
    check("t1_latency", tc - last_e, 102);
    check("t1_edges", edge_cnt - ec0, 1);
    wait_status("t1_status", 32'h8000_0000, 0);
    send_cmd(0, 100, ec0);
    wait_status("t1b_status", 32'h8000_0001, 0);

    // delay 2, offset 0: third edge after acceptance, 2 cycles later
    send_cmd(2, 0, ec0);
    wait_trig(5000, tc);
    check("t2_latency", tc - last_e, 2);
    check("t2_edges", edge_cnt - ec0, 3);
    wait_status("t2_status", 32'h8000_0002, 0);

    // offset past the second length: MISS on the following edge
    tcnt0 = trig_count;
    send_cmd(0, 1200, ec0);
    wait_status("t3_status", 32'h4000_0003, 0);
    check("t3_no_trig", trig_count - tcnt0, 0);

    // PPS stops while armed
    send_cmd(3, 0, ec0);
    pps_en = 1'b0;
    wait_status("t4_status", 32'h2000_0004, 0);
    check("t4_lost", pps_lost, 1'b1);
    check("t4_lock", pps_lock, 1'b0);
    repeat (20) begin
      tick();
      check("t4_tready", s_axis_tready, 1'b0);
    end
    pps_en = 1'b1;
    wait_lock(2500);

    // abort while waiting, then backpressure the status for 10 cycles
    tcnt0 = trig_count;
    send_cmd(0, 500, ec0);
    n = 0;
    while (edge_cnt == ec0 && n < 2000) begin tick(); n++; end
    repeat (20) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    s_axis_tdata  = {16'h0, 16'd0, 32'd5};
    s_axis_tvalid = 1'b1;
    wait_status("t5_status", 32'h1000_0005, 10);
    check("t5_no_trig", trig_count - tcnt0, 0);

    // reset while waiting: pending command vanishes
    tcnt0 = trig_count;
    send_cmd(0, 600, ec0);
    n = 0;
    while (edge_cnt == ec0 && n < 2000) begin tick(); n++; end
    repeat (100) tick();
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    check("t6_rst_outputs", {trig, m_axis_tvalid, s_axis_tready, pps_lock, pps_lost}, 5'b0);
    wait_lock(2500);
    check("t6_no_trig", trig_count - tcnt0, 0);
    send_cmd(0, 10, ec0);
    wait_status("t6_status", 32'h8000_0000, 0);

    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
